// File: rtl/if_stage_if.sv
// Fetch-stage bundle: imem request/response, EX redirect and decode handshake.
// master is the fetch stage; slave is the memory/decode environment.
interface if_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            id_valid;
    logic            id_ready;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;
    logic [6:0]      id_opcode;

    modport master (
        output imem_req_valid, imem_req_addr,
        output id_valid, id_pc, id_instr, id_opcode,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        input  id_valid, id_pc, id_instr, id_opcode,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues in-order imem requests and
// buffers returned instructions for decode; redirects squash stale responses.
module if_stage #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input logic        clk,
    input logic        rst,
    if_stage_if.master bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [AW+1:0] sum_t;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] pcq_q [FIFO_DEPTH];
    logic [XLEN-1:0] bpc_q [FIFO_DEPTH];
    logic [31:0]     bins_q [FIFO_DEPTH];
    ptr_t            pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
    ptr_t            b_rd_q, b_rd_d, b_wr_q, b_wr_d;
    cnt_t            buf_cnt_q, buf_cnt_d;
    cnt_t            keep_cnt_q, keep_cnt_d;
    cnt_t            drop_cnt_q, drop_cnt_d;

    sum_t used;
    logic req_valid;
    logic req_fire;
    logic resp_keep;
    logic resp_drop;
    logic id_valid;
    logic pop;
    logic unused_lo;

    // Credit: buffered plus in-flight (kept or stale) never exceeds the depth.
    assign used = sum_t'(buf_cnt_q) + sum_t'(keep_cnt_q) + sum_t'(drop_cnt_q);
    assign req_valid = !rst && !bus.redirect_valid
                       && (used < sum_t'(FIFO_DEPTH));
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign resp_drop = bus.imem_resp_valid && (drop_cnt_q != '0);
    assign resp_keep = bus.imem_resp_valid && (drop_cnt_q == '0);
    assign id_valid  = (buf_cnt_q != '0);
    assign pop       = id_valid && bus.id_ready;
    assign unused_lo = ^bus.redirect_pc[1:0];

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.id_valid       = id_valid;
    assign bus.id_pc          = id_valid ? bpc_q[b_rd_q] : '0;
    assign bus.id_instr       = id_valid ? bins_q[b_rd_q] : '0;
    assign bus.id_opcode      = bus.id_instr[6:0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pcq_rd_d   = pcq_rd_q;
        pcq_wr_d   = pcq_wr_q;
        b_rd_d     = b_rd_q;
        b_wr_d     = b_wr_q;
        buf_cnt_d  = buf_cnt_q;
        keep_cnt_d = keep_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
            pcq_rd_d   = '0;
            pcq_wr_d   = '0;
            b_rd_d     = '0;
            b_wr_d     = '0;
            buf_cnt_d  = '0;
            keep_cnt_d = '0;
            // A response landing in the redirect cycle consumes one outstanding slot.
            drop_cnt_d = drop_cnt_q + keep_cnt_q
                         - cnt_t'(bus.imem_resp_valid);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                pcq_wr_d   = pcq_wr_q + ptr_t'(1);
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - cnt_t'(1);
            end
            if (resp_keep) begin
                pcq_rd_d = pcq_rd_q + ptr_t'(1);
                b_wr_d   = b_wr_q + ptr_t'(1);
            end
            if (pop) begin
                b_rd_d = b_rd_q + ptr_t'(1);
            end
            keep_cnt_d = keep_cnt_q + cnt_t'(req_fire) - cnt_t'(resp_keep);
            buf_cnt_d  = buf_cnt_q + cnt_t'(resp_keep) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            pcq_rd_q   <= '0;
            pcq_wr_q   <= '0;
            b_rd_q     <= '0;
            b_wr_q     <= '0;
            buf_cnt_q  <= '0;
            keep_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pcq_rd_q   <= pcq_rd_d;
            pcq_wr_q   <= pcq_wr_d;
            b_rd_q     <= b_rd_d;
            b_wr_q     <= b_wr_d;
            buf_cnt_q  <= buf_cnt_d;
            keep_cnt_q <= keep_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_q[pcq_wr_q] <= fetch_pc_q;
        end
        if (resp_keep) begin
            bpc_q[b_wr_q]  <= pcq_q[pcq_rd_q];
            bins_q[b_wr_q] <= bus.imem_resp_data;
        end
    end

    a_resp_owned: assert property (@(posedge clk) disable iff (rst)
        bus.imem_resp_valid |-> (drop_cnt_q != '0 || keep_cnt_q != '0));
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with an in-order imem model of adjustable latency.
// Instruction words are addr ^ 32'hA5A5_0000 so data/PC pairing is checkable.
module tb_if_stage;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   lat;
    int   cyc;
    logic [31:0] exp_id;
    logic [31:0] exp_i;
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    if_stage_if #(.XLEN(32)) bus();

    if_stage #(
        .XLEN(32),
        .RESET_PC(32'h0000_0000),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // imem model: accepts at an edge, answers lat cycles after the request cycle
    initial begin
        cyc = 0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                mq_addr.delete();
                mq_due.delete();
            end else begin
                if (bus.imem_resp_valid && mq_addr.size() > 0) begin
                    void'(mq_addr.pop_front());
                    void'(mq_due.pop_front());
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    mq_addr.push_back(bus.imem_req_addr);
                    mq_due.push_back(cyc - 1 + lat);
                end
            end
            #1;
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mq_addr[0] ^ 32'hA5A5_0000;
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = '0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        lat = 1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b1;
        bus.imem_req_ready = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid got %b exp 0", bus.imem_req_valid);
        end
        checks++;
        if (bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_id_valid got %b exp 0", bus.id_valid);
        end
        checks++;
        if (bus.id_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_id_pc got %h exp 0", bus.id_pc);
        end
        checks++;
        if (bus.id_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_id_instr got %h exp 0", bus.id_instr);
        end
        checks++;
        if (bus.id_opcode !== 7'h0) begin
            errors++;
            $display("FAIL reset_id_opcode got %h exp 0", bus.id_opcode);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            checks++;
            if (bus.imem_req_valid !== 1'b1
                || bus.imem_req_addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stream_req k=%0d got v=%b a=%h exp v=1 a=%h",
                         k, bus.imem_req_valid, bus.imem_req_addr, 4 * k);
            end
            if (k < 2) begin
                checks++;
                if (bus.id_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stream_early_valid k=%0d got %b exp 0",
                             k, bus.id_valid);
                end
            end else begin
                exp_id = 32'(4 * (k - 2));
                exp_i  = exp_id ^ 32'hA5A5_0000;
                checks++;
                if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_id
                    || bus.id_instr !== exp_i
                    || bus.id_opcode !== exp_i[6:0]) begin
                    errors++;
                    $display("FAIL stream_id k=%0d got v=%b pc=%h i=%h op=%h exp pc=%h i=%h",
                             k, bus.id_valid, bus.id_pc, bus.id_instr,
                             bus.id_opcode, exp_id, exp_i);
                end
            end
        end
    endtask

    task automatic test_stall();
        exp_id = 32'd24;
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            bus.id_ready = 1'b0;
            #1;
            exp_i = exp_id ^ 32'hA5A5_0000;
            checks++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_id
                || bus.id_instr !== exp_i) begin
                errors++;
                $display("FAIL stall_hold s=%0d got v=%b pc=%h i=%h exp pc=%h i=%h",
                         s, bus.id_valid, bus.id_pc, bus.id_instr, exp_id, exp_i);
            end
            if (s >= 2) begin
                checks++;
                if (bus.imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_credit s=%0d got req_valid=%b exp 0",
                             s, bus.imem_req_valid);
                end
            end
        end
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            bus.id_ready = 1'b1;
            #1;
            exp_i = exp_id ^ 32'hA5A5_0000;
            checks++;
            if (bus.id_valid !== 1'b1 || bus.id_pc !== exp_id
                || bus.id_instr !== exp_i) begin
                errors++;
                $display("FAIL stall_release s=%0d got v=%b pc=%h i=%h exp pc=%h i=%h",
                         s, bus.id_valid, bus.id_pc, bus.id_instr, exp_id, exp_i);
            end
            exp_id = exp_id + 32'd4;
        end
    endtask

    task automatic expect_ids(input string name, input logic [31:0] first,
                              input int n);
        int got;
        got = 0;
        exp_id = first;
        for (int c = 0; c < 20 && got < n; c++) begin
            @(negedge clk);
            #1;
            if (bus.id_valid === 1'b1) begin
                exp_i = exp_id ^ 32'hA5A5_0000;
                checks++;
                if (bus.id_pc !== exp_id || bus.id_instr !== exp_i) begin
                    errors++;
                    $display("FAIL %s_id got pc=%h i=%h exp pc=%h i=%h",
                             name, bus.id_pc, bus.id_instr, exp_id, exp_i);
                end
                exp_id = exp_id + 32'd4;
                got++;
            end
        end
        checks++;
        if (got != n) begin
            errors++;
            $display("FAIL %s_timeout got %0d instrs exp %0d", name, got, n);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        lat = 3;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL redir_req0 got v=%b a=%h exp v=1 a=0",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h4) begin
            errors++;
            $display("FAIL redir_req1 got v=%b a=%h exp v=1 a=4",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h100;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_req_block got %b exp 0", bus.imem_req_valid);
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_target got v=%b a=%h exp v=1 a=100",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        checks++;
        if (bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush got id_valid=%b exp 0", bus.id_valid);
        end
        expect_ids("redir", 32'h100, 2);
    endtask

    task automatic test_misalign();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        #1;
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h4) begin
            errors++;
            $display("FAIL misal_pop got v=%b pc=%h exp v=1 pc=4",
                     bus.id_valid, bus.id_pc);
        end
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL misal_req_block got %b exp 0", bus.imem_req_valid);
        end
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
            errors++;
            $display("FAIL misal_addr got v=%b a=%h exp v=1 a=100",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        checks++;
        if (bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL misal_flush got id_valid=%b exp 0", bus.id_valid);
        end
        expect_ids("misal", 32'h100, 2);
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b1
            || bus.imem_req_addr !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_addr0 got v=%b a=%h exp v=1 a=fffffffc",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr1 got v=%b a=%h exp v=1 a=0",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        expect_ids("wrap", 32'hFFFF_FFFC, 2);
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 3;
        bus.id_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h0) begin
            errors++;
            $display("FAIL rmid_pre got v=%b pc=%h exp v=1 pc=0",
                     bus.id_valid, bus.id_pc);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_req_in_rst got %b exp 0", bus.imem_req_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.id_ready = 1'b1;
        #1;
        checks++;
        if (bus.id_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_flush got id_valid=%b exp 0", bus.id_valid);
        end
        checks++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            errors++;
            $display("FAIL rmid_restart got v=%b a=%h exp v=1 a=0",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        expect_ids("rmid", 32'h0, 3);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        lat    = 1;
        rst    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.id_ready       = 1'b1;
        bus.imem_req_ready = 1'b1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misalign();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
